// File: rtl/ft245_sync_tx_fifo_if.sv
// FPGA-side word stream plus FT245 synchronous-mode transmit pins.
// master = upstream logic / FT2232H model, slave = the transmit engine.
interface ft245_sync_tx_fifo_if #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] din_i;
    logic              din_valid_i;
    logic              din_ready_o;
    logic [7:0]        adbus_o;
    logic              txe_i;
    logic              wr_o;
    logic              oe_o;
    logic [LW-1:0]     level_o;
    logic              ovf_o;
    logic              blinker_o;

    modport master (
        output din_i, din_valid_i, txe_i,
        input  din_ready_o, adbus_o, wr_o, oe_o, level_o, ovf_o, blinker_o
    );

    modport slave (
        input  din_i, din_valid_i, txe_i,
        output din_ready_o, adbus_o, wr_o, oe_o, level_o, ovf_o, blinker_o
    );
endinterface

// File: rtl/ft245_sync_tx_fifo.sv
// FT245 synchronous-mode transmit engine: word FIFO (or counter source) serialised
// LSB byte first onto ADBUS under TXE#/WR# flow control, all in the CLKOUT domain.
module ft245_sync_tx_fifo #(
    parameter int WORD_W    = 32,
    parameter int DEPTH     = 16,
    parameter int MODE      = 0,
    parameter int BLINK_DIV = 1024
) (
    input logic                  clk_i,
    input logic                  rst_i,
    ft245_sync_tx_fifo_if.slave  bus
);
    localparam int NB = WORD_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_cnt;
    logic [IW-1:0]     r_idx;
    logic              r_ovf;
    logic              r_blink;
    logic [BW-1:0]     r_blink_cnt;

    logic [LW-1:0]     w_level;
    logic              w_full;
    logic              w_src_avail;
    logic              w_xfer;
    logic              w_last;
    logic              w_pop;
    logic              w_push;
    logic [WORD_W-1:0] w_head;
    logic [7:0]        w_bytes [NB];

    // Extra pointer bit distinguishes full from empty.
    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_level == LW'(DEPTH));
    assign w_src_avail = (MODE != 0) ? 1'b1 : (w_level != '0);
    assign w_xfer      = (r_state == ST_SEND) && !bus.txe_i;
    assign w_last      = (r_idx == IW'(NB - 1));
    assign w_pop       = w_src_avail && ((r_state == ST_IDLE) || (w_xfer && w_last));
    assign w_push      = (MODE == 0) && bus.din_valid_i && !w_full;
    assign w_head      = (MODE != 0) ? r_cnt : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop && (MODE == 0)) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if ((MODE == 0) && bus.din_valid_i && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_pop && (MODE != 0)) begin
            r_cnt <= r_cnt + WORD_W'(1);
        end
    end

    // Last-byte transfer reloads the shift register in the same edge: no bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_idx   <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (!w_last) begin
                            r_idx <= r_idx + IW'(1);
                        end else if (w_pop) begin
                            r_shift <= w_head;
                            r_idx   <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_xfer) begin
            if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign w_bytes[gi] = r_shift[8*gi +: 8];
    end

    // WR# is gated by reset directly so it can never pulse low during reset.
    assign bus.wr_o        = rst_i | !w_xfer;
    assign bus.adbus_o     = w_bytes[r_idx];
    assign bus.oe_o        = 1'b1;
    assign bus.din_ready_o = (MODE == 0) && !rst_i && !w_full;
    assign bus.level_o     = (MODE == 0) ? w_level : '0;
    assign bus.ovf_o       = r_ovf;
    assign bus.blinker_o   = r_blink;
endmodule
